stream_mux_rr: RTL and testbench

- Parametrised N:1 stream multiplexer. It replaces the fixed-width combinational mux trees with a registered, handshaked channel selector.
- Each of NUM_CH input channels carries DATA_W-bit words with a valid/ready handshake.
- Two selection modes:
  - explicit: a select input picks the channel.
  - round-robin: fair arbitration among valid channels.
- Sits between per-channel producers and a single downstream consumer. Output is registered: 1-cycle latency, full throughput.

---
 rtl/stream_mux_rr.sv | 89 ++++++++
 tb/tb_stream_mux_rr.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N:1 stream multiplexer with explicit or round-robin channel select
module stream_mux_rr #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         select,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        valid_in,
  output logic [NUM_CH-1:0]        ready_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [SEL_W-1:0]         chan_out,
  output logic                     valid_out,
  input  logic                     ready_in
);

  logic              load;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_off;
  logic [SEL_W-1:0]  rr_next;
  logic [SEL_W:0]    rr_sum;
  logic [NUM_CH-1:0] rot;
  logic [DATA_W-1:0] grant_data;

  assign load = !valid_out || ready_in;

  // Rotate valids so bit 0 is the channel at rr_ptr; lowest set bit is the winner's offset.
  assign rot = NUM_CH'({valid_in, valid_in} >> rr_ptr);

  always_comb begin
    rr_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) rr_off = SEL_W'(i);
    end
    rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
    if (rr_sum >= (SEL_W+1)'(NUM_CH)) rr_sum = rr_sum - (SEL_W+1)'(NUM_CH);
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode) begin
      grant_vld = |valid_in;
      grant_idx = rr_sum[SEL_W-1:0];
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (select == SEL_W'(k) && valid_in[k]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    ready_out  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == SEL_W'(k)) grant_data = data_in[k*DATA_W +: DATA_W];
      ready_out[k] = !rst && load && grant_vld && (grant_idx == SEL_W'(k));
    end
  end

  assign rr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      chan_out  <= '0;
      valid_out <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (grant_vld) begin
        data_out  <= grant_data;
        chan_out  <= grant_idx;
        valid_out <= 1'b1;
        if (mode) rr_ptr <= rr_next;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed self-checking bench for stream_mux_rr
module tb_stream_mux_rr;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [3:0]   select;
  logic [127:0] data_in;
  logic [15:0]  valid_in;
  logic [15:0]  ready_out;
  logic [7:0]   data_out;
  logic [3:0]   chan_out;
  logic         valid_out;
  logic         ready_in;

  logic         mode12;
  logic [3:0]   select12;
  logic [95:0]  data_in12;
  logic [11:0]  valid_in12;
  logic [11:0]  ready_out12;
  logic [7:0]   data_out12;
  logic [3:0]   chan_out12;
  logic         valid_out12;
  logic         ready_in12;

  logic [7:0]   ch_data [16];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    data_in   = '0;
    data_in12 = '0;
    for (int k = 0; k < 16; k++) data_in[k*8 +: 8] = ch_data[k];
    for (int k = 0; k < 12; k++) data_in12[k*8 +: 8] = ch_data[k];
  end

  stream_mux_rr dut (
    .clk(clk), .rst(rst), .mode(mode), .select(select), .data_in(data_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .chan_out(chan_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  stream_mux_rr #(.NUM_CH(12), .DATA_W(8)) dut12 (
    .clk(clk), .rst(rst), .mode(mode12), .select(select12), .data_in(data_in12),
    .valid_in(valid_in12), .ready_out(ready_out12), .data_out(data_out12),
    .chan_out(chan_out12), .valid_out(valid_out12), .ready_in(ready_in12)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ready(input string name, input logic [15:0] exp);
    #1;
    checks++;
    if (ready_out !== exp) begin
      errors++;
      $display("FAIL %s ready_out got %h exp %h", name, ready_out, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic v, input logic [3:0] c, input logic [7:0] d);
    checks++;
    if (valid_out !== v || chan_out !== c || data_out !== d) begin
      errors++;
      $display("FAIL %s got v=%b ch=%0d d=%h exp v=%b ch=%0d d=%h",
               name, valid_out, chan_out, data_out, v, c, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; valid_in = 16'hFFFF; ready_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_out("reset_out", 1'b0, 4'd0, 8'h00);
      expect_ready("reset_ready", 16'h0000);
    end
    rst = 1'b0;
    expect_ready("reset_first_grant", 16'h0001);
    tick();
    expect_out("reset_first_word", 1'b1, 4'd0, 8'h5E);
  endtask

  task automatic test_explicit();
    mode = 1'b0; select = 4'd5; valid_in = 16'hFFFF; ready_in = 1'b1;
    expect_ready("explicit_sel5", 16'h0020);
    tick();
    expect_out("explicit_word5", 1'b1, 4'd5, 8'hA5);
    select = 4'd15;
    expect_ready("explicit_sel15", 16'h8000);
    tick();
    expect_out("explicit_word15", 1'b1, 4'd15, 8'h3C);
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [6];
    seq = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0, 4'd5};
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 1'b1; valid_in = 16'h8421; ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_ready("rr_ready", 16'h0001 << seq[i]);
      tick();
      expect_out("rr_word", 1'b1, seq[i], ch_data[seq[i]]);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 1'b1; valid_in = 16'h0006; ready_in = 1'b1;
    #1;
    tick();
    expect_out("bp_first", 1'b1, 4'd1, 8'h11);
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_ready("bp_stall_ready", 16'h0000);
      tick();
      expect_out("bp_stall_hold", 1'b1, 4'd1, 8'h11);
    end
    ready_in = 1'b1;
    expect_ready("bp_release_ready", 16'h0004);
    tick();
    expect_out("bp_release_word", 1'b1, 4'd2, 8'h22);
    expect_ready("bp_next_ready", 16'h0002);
    tick();
    expect_out("bp_next_word", 1'b1, 4'd1, 8'h11);
  endtask

  task automatic test_wrap_empty();
    valid_in = 16'h8000;
    expect_ready("wrap_ready15", 16'h8000);
    tick();
    expect_out("wrap_word15", 1'b1, 4'd15, 8'h3C);
    valid_in = 16'h0001;
    expect_ready("wrap_ready0", 16'h0001);
    tick();
    expect_out("wrap_word0", 1'b1, 4'd0, 8'h5E);
    valid_in = 16'h0000;
    expect_ready("empty_ready", 16'h0000);
    tick();
    expect_out("empty_drop", 1'b0, 4'd0, 8'h5E);
  endtask

  task automatic test_mid_reset();
    valid_in = 16'h0004; ready_in = 1'b0;
    #1;
    tick();
    expect_out("mid_load", 1'b1, 4'd2, 8'h22);
    tick();
    expect_out("mid_hold", 1'b1, 4'd2, 8'h22);
    rst = 1'b1;
    expect_ready("mid_rst_ready", 16'h0000);
    tick();
    expect_out("mid_rst_out", 1'b0, 4'd0, 8'h00);
    rst = 1'b0; valid_in = 16'h8001; ready_in = 1'b1;
    expect_ready("mid_ptr_reset", 16'h0001);
    tick();
    expect_out("mid_after", 1'b1, 4'd0, 8'h5E);
  endtask

  task automatic test_out_of_range();
    mode12 = 1'b0; select12 = 4'd13; valid_in12 = 12'hFFF; ready_in12 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ready_out12 !== 12'h000 || valid_out12 !== 1'b0) begin
        errors++;
        $display("FAIL oor_sel13 got ready=%h valid=%b exp ready=000 valid=0", ready_out12, valid_out12);
      end
      tick();
    end
    select12 = 4'd11;
    #1;
    checks++;
    if (ready_out12 !== 12'h800) begin
      errors++;
      $display("FAIL oor_sel11_ready got %h exp 800", ready_out12);
    end
    tick();
    checks++;
    if (valid_out12 !== 1'b1 || chan_out12 !== 4'd11 || data_out12 !== 8'hBB) begin
      errors++;
      $display("FAIL oor_sel11_word got v=%b ch=%0d d=%h exp v=1 ch=11 d=bb", valid_out12, chan_out12, data_out12);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) ch_data[k] = 8'(k * 17);
    ch_data[0]  = 8'h5E;
    ch_data[5]  = 8'hA5;
    ch_data[15] = 8'h3C;
    rst = 1'b1; mode = 1'b1; select = 4'd0; valid_in = '0; ready_in = 1'b1;
    mode12 = 1'b0; select12 = 4'd13; valid_in12 = '0; ready_in12 = 1'b1;
    test_reset();
    test_explicit();
    test_round_robin();
    test_back_to_back();
    test_wrap_empty();
    test_mid_reset();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
